// File: rtl/apb_cdc_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | apb_cdc_pkg                                                           |
// | Shared types, default widths and round-robin pick for the APB arbiter |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package apb_cdc_pkg;

    localparam int c_MAX_REQ        = 16;
    localparam int c_PTR_W          = $clog2(c_MAX_REQ);
    localparam int c_DEF_ADDR_WIDTH = 32;
    localparam int c_DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // First set bit at or above ptr, wrapping at num; one-hot result, zero if no request.
    function automatic logic [c_MAX_REQ-1:0] rr_pick(
        input logic [c_MAX_REQ-1:0] req,
        input logic [c_PTR_W-1:0]   ptr,
        input int                   num
    );
        logic [c_MAX_REQ-1:0] grant;
        logic                 found;
        int                   idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < c_MAX_REQ; k++) begin
            if (k < num) begin
                idx = int'(ptr) + k;
                if (idx >= num) begin
                    idx = idx - num;
                end
                if (!found && req[idx[c_PTR_W-1:0]]) begin
                    grant[idx[c_PTR_W-1:0]] = 1'b1;
                    found                   = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_cdc_arbiter_rr.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_arbiter                                                            |
// | Combinational round-robin pick with a registered rotation pointer.    |
// | Optional macro APB_CDC_ARB_PRIO0_EN: requester 0 always wins.         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module rr_arbiter
    import apb_cdc_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       advance,
    output logic [NUM_REQ-1:0]         grant_onehot,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int c_IDX_W = $clog2(NUM_REQ);

    logic [c_IDX_W-1:0]   r_ptr;
    logic [c_MAX_REQ-1:0] w_req_ext;
    logic [c_MAX_REQ-1:0] w_pick;
    logic                 w_move_ptr;

    assign w_req_ext = c_MAX_REQ'(req);

`ifdef APB_CDC_ARB_PRIO0_EN
    assign w_pick     = req[0] ? c_MAX_REQ'(1) : rr_pick(w_req_ext, c_PTR_W'(r_ptr), NUM_REQ);
    // A priority win by requester 0 leaves the rotation where it was.
    assign w_move_ptr = advance && (|grant_onehot) && !grant_onehot[0];
`else
    assign w_pick     = rr_pick(w_req_ext, c_PTR_W'(r_ptr), NUM_REQ);
    assign w_move_ptr = advance && (|grant_onehot);
`endif

    assign grant_onehot = w_pick[NUM_REQ-1:0];

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < c_MAX_REQ; i++) begin
            if (w_pick[i]) begin
                grant_idx = c_IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_move_ptr) begin
            r_ptr <= (grant_idx == c_IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_cdc_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | apb_cdc_arbiter                                                       |
// | N-to-1 round-robin APB arbiter feeding the apb_cdc source port.       |
// | Optional macro APB_CDC_ARB_PRIO0_EN: requester 0 is high priority.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module apb_cdc_arbiter
    import apb_cdc_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int APB_ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter int APB_DATA_WIDTH = c_DEF_DATA_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0] req_PADDR_i,
    input  logic [NUM_REQ*APB_DATA_WIDTH-1:0] req_PWDATA_i,
    input  logic [NUM_REQ-1:0]                req_PWRITE_i,
    input  logic [NUM_REQ-1:0]                req_PSEL_i,
    input  logic [NUM_REQ-1:0]                req_PENABLE_i,
    output logic [APB_DATA_WIDTH-1:0]         req_PRDATA_o,
    output logic [NUM_REQ-1:0]                req_PREADY_o,
    output logic [NUM_REQ-1:0]                req_PSLVERR_o,
    output logic [APB_ADDR_WIDTH-1:0]         cdc_PADDR_o,
    output logic [APB_DATA_WIDTH-1:0]         cdc_PWDATA_o,
    output logic                              cdc_PWRITE_o,
    output logic                              cdc_PSEL_o,
    output logic                              cdc_PENABLE_o,
    input  logic [APB_DATA_WIDTH-1:0]         cdc_PRDATA_i,
    input  logic                              cdc_PREADY_i,
    input  logic                              cdc_PSLVERR_i,
    output logic [NUM_REQ-1:0]                grant_o
);

    localparam int c_IDX_W = $clog2(NUM_REQ);

    apb_state_e                r_state;
    logic [NUM_REQ-1:0]        r_grant;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [APB_DATA_WIDTH-1:0] r_pwdata;
    logic                      r_pwrite;
    logic                      r_psel;
    logic                      r_penable;

    logic [NUM_REQ-1:0]        w_pick;
    logic [c_IDX_W-1:0]        w_pick_idx;
    logic                      w_start;
    logic                      w_done;
    logic [NUM_REQ-1:0]        w_resp;
    logic [APB_ADDR_WIDTH-1:0] w_addr  [NUM_REQ];
    logic [APB_DATA_WIDTH-1:0] w_wdata [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr[g]  = req_PADDR_i[g*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
        assign w_wdata[g] = req_PWDATA_i[g*APB_DATA_WIDTH +: APB_DATA_WIDTH];
    end

    assign w_start = (r_state == IDLE) && (|req_PSEL_i);
    assign w_done  = (r_state == ACCESS) && cdc_PREADY_i;

    // The pointer moves at capture; it is only consulted in IDLE, so this is
    // indistinguishable from moving it at completion.
    rr_arbiter #(
        .NUM_REQ      (NUM_REQ)
    ) u_rr_arbiter (
        .clk          (clk),
        .rst          (rst),
        .req          (req_PSEL_i),
        .advance      (w_start),
        .grant_onehot (w_pick),
        .grant_idx    (w_pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pwrite  <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state  <= SETUP;
                        r_grant  <= w_pick;
                        r_paddr  <= w_addr[w_pick_idx];
                        r_pwdata <= w_wdata[w_pick_idx];
                        r_pwrite <= req_PWRITE_i[w_pick_idx];
                        r_psel   <= 1'b1;
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                end
                ACCESS: begin
                    if (cdc_PREADY_i) begin
                        r_state   <= IDLE;
                        r_grant   <= '0;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_grant   <= '0;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    // A winner that abandoned its transfer gets no response.
    assign w_resp        = r_grant & req_PSEL_i & req_PENABLE_i & {NUM_REQ{w_done}};
    assign req_PREADY_o  = w_resp;
    assign req_PSLVERR_o = w_resp & {NUM_REQ{cdc_PSLVERR_i}};
    assign req_PRDATA_o  = w_done ? cdc_PRDATA_i : '0;

    assign cdc_PADDR_o   = r_paddr;
    assign cdc_PWDATA_o  = r_pwdata;
    assign cdc_PWRITE_o  = r_pwrite;
    assign cdc_PSEL_o    = r_psel;
    assign cdc_PENABLE_o = r_penable;
    assign grant_o       = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_apb_cdc_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_apb_cdc_arbiter                                                    |
// | Scoreboard bench: requester/slave models around apb_cdc_arbiter.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_apb_cdc_arbiter;

    localparam int NUM_REQ = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ*AW-1:0] req_PADDR_i;
    logic [NUM_REQ*DW-1:0] req_PWDATA_i;
    logic [NUM_REQ-1:0]    req_PWRITE_i;
    logic [NUM_REQ-1:0]    req_PSEL_i;
    logic [NUM_REQ-1:0]    req_PENABLE_i;
    logic [DW-1:0]         req_PRDATA_o;
    logic [NUM_REQ-1:0]    req_PREADY_o;
    logic [NUM_REQ-1:0]    req_PSLVERR_o;
    logic [AW-1:0]         cdc_PADDR_o;
    logic [DW-1:0]         cdc_PWDATA_o;
    logic                  cdc_PWRITE_o;
    logic                  cdc_PSEL_o;
    logic                  cdc_PENABLE_o;
    logic [DW-1:0]         cdc_PRDATA_i;
    logic                  cdc_PREADY_i;
    logic                  cdc_PSLVERR_i;
    logic [NUM_REQ-1:0]    grant_o;

    apb_cdc_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_PADDR_i   (req_PADDR_i),
        .req_PWDATA_i  (req_PWDATA_i),
        .req_PWRITE_i  (req_PWRITE_i),
        .req_PSEL_i    (req_PSEL_i),
        .req_PENABLE_i (req_PENABLE_i),
        .req_PRDATA_o  (req_PRDATA_o),
        .req_PREADY_o  (req_PREADY_o),
        .req_PSLVERR_o (req_PSLVERR_o),
        .cdc_PADDR_o   (cdc_PADDR_o),
        .cdc_PWDATA_o  (cdc_PWDATA_o),
        .cdc_PWRITE_o  (cdc_PWRITE_o),
        .cdc_PSEL_o    (cdc_PSEL_o),
        .cdc_PENABLE_o (cdc_PENABLE_o),
        .cdc_PRDATA_i  (cdc_PRDATA_i),
        .cdc_PREADY_i  (cdc_PREADY_i),
        .cdc_PSLVERR_i (cdc_PSLVERR_i),
        .grant_o       (grant_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            idx;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          wr;
        logic [DW-1:0] rdata;
        logic          err;
    } txn_t;

    txn_t               sb[$];
    int                 n_cmp  = 0;
    int                 n_fail = 0;
    logic [AW-1:0]      a_addr  [NUM_REQ];
    logic [DW-1:0]      a_wdata [NUM_REQ];
    logic               a_wr    [NUM_REQ];
    int                 left    [NUM_REQ];
    int                 cfg_wait;
    logic [DW-1:0]      cfg_rdata;
    logic               cfg_err;
    logic [NUM_REQ-1:0] sel_q  = '0;
    logic [NUM_REQ-1:0] done_q = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_slave(input int w, input logic [DW-1:0] rd, input logic e);
        cfg_wait      = w;
        cfg_rdata     = rd;
        cfg_err       = e;
        cdc_PRDATA_i  = rd;
        cdc_PSLVERR_i = e;
    endtask

    task automatic issue(input int i, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic wr, input int n);
        a_addr[i]  = addr;
        a_wdata[i] = wdata;
        a_wr[i]    = wr;
        left[i]    = n;
        req_PADDR_i[i*AW +: AW]  = addr;
        req_PWDATA_i[i*DW +: DW] = wdata;
        req_PWRITE_i[i]          = wr;
        req_PSEL_i[i]            = 1'b1;
    endtask

    task automatic push_exp(input int i);
        txn_t t;
        t.idx   = i;
        t.addr  = a_addr[i];
        t.wdata = a_wdata[i];
        t.wr    = a_wr[i];
        t.rdata = cfg_rdata;
        t.err   = cfg_err;
        sb.push_back(t);
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    // Downstream slave: PREADY after cfg_wait ACCESS wait states.
    initial begin
        int wcnt = 0;
        cdc_PREADY_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cdc_PSEL_o && cdc_PENABLE_o) begin
                if (wcnt >= cfg_wait) begin
                    cdc_PREADY_i = 1'b1;
                end else begin
                    cdc_PREADY_i = 1'b0;
                    wcnt++;
                end
            end else begin
                cdc_PREADY_i = 1'b0;
                wcnt         = 0;
            end
        end
    end

    // Requester masters: PENABLE one cycle after PSEL, re-request while transfers remain.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (done_q[i]) begin
                    req_PENABLE_i[i] = 1'b0;
                    if (left[i] > 0) left[i]--;
                    req_PSEL_i[i] = (left[i] != 0);
                end else begin
                    req_PENABLE_i[i] = sel_q[i] & req_PSEL_i[i];
                end
            end
        end
    end

    // Scoreboard monitor: downstream command against queue head, responses pop it.
    always @(negedge clk) begin
        txn_t               cur;
        logic [NUM_REQ-1:0] oh;
        sel_q  = req_PSEL_i;
        done_q = req_PREADY_o;
        if (!rst) begin
            if (cdc_PSEL_o) begin
                chk("xfer_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    cur = sb[0];
                    oh  = 4'(1) << cur.idx;
                    chk("grant", grant_o, oh);
                    chk("cdc_paddr", cdc_PADDR_o, cur.addr);
                    chk("cdc_pwdata", cdc_PWDATA_o, cur.wdata);
                    chk("cdc_pwrite", cdc_PWRITE_o, cur.wr);
                end
            end
            if (req_PREADY_o != '0) begin
                chk("resp_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    cur = sb.pop_front();
                    oh  = 4'(1) << cur.idx;
                    chk("req_pready", req_PREADY_o, oh);
                    chk("req_pslverr", req_PSLVERR_o, cur.err ? oh : 4'b0000);
                    chk("req_prdata", req_PRDATA_o, cur.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc = 0;
        rst           = 1'b1;
        req_PADDR_i   = '0;
        req_PWDATA_i  = '0;
        req_PWRITE_i  = '0;
        req_PSEL_i    = '0;
        req_PENABLE_i = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            left[i] = 0; a_addr[i] = '0; a_wdata[i] = '0; a_wr[i] = 1'b0;
        end
        set_slave(0, '0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_grant", grant_o, 4'b0000);
        chk("rst_psel", cdc_PSEL_o, 1'b0);
        chk("rst_penable", cdc_PENABLE_o, 1'b0);
        chk("rst_paddr", cdc_PADDR_o, 32'h0);
        chk("rst_pwdata", cdc_PWDATA_o, 32'h0);
        chk("rst_pwrite", cdc_PWRITE_o, 1'b0);
        chk("rst_pready", req_PREADY_o, 4'b0000);
        chk("rst_pslverr", req_PSLVERR_o, 4'b0000);
        chk("rst_prdata", req_PRDATA_o, 32'h0);
        #2 rst = 1'b0;

        // Round robin: all four request, requester 0 twice.
        @(posedge clk); #1;
        set_slave(0, 32'hA0A0_0001, 1'b0);
        for (int i = 0; i < NUM_REQ; i++)
            issue(i, 32'h100 + i*16, 32'hC0DE_0000 + i, 1'b1, (i == 0) ? 2 : 1);
`ifdef APB_CDC_ARB_PRIO0_EN
        push_exp(0); push_exp(0); push_exp(1); push_exp(2); push_exp(3);
`else
        push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
`endif
        drain("rr_drain", 80);

        // Requesters 0 and 3 competing with the pointer at 1.
        @(posedge clk); #1;
        set_slave(1, 32'h5555_AAAA, 1'b0);
        issue(0, 32'h200, 32'h1111_0000, 1'b0, 2);
        issue(3, 32'h300, 32'h3333_0000, 1'b1, 2);
`ifdef APB_CDC_ARB_PRIO0_EN
        push_exp(0); push_exp(0); push_exp(3); push_exp(3);
`else
        push_exp(3); push_exp(0); push_exp(3); push_exp(0);
`endif
        drain("pair_drain", 80);

        // Single write with latency checks.
        @(posedge clk); #1;
        set_slave(0, 32'h0BAD_F00D, 1'b0);
        issue(1, 32'h40, 32'hDEAD_BEEF, 1'b1, 1);
        push_exp(1);
        @(negedge clk);
        chk("sw_idle_psel", cdc_PSEL_o, 1'b0);
        @(negedge clk);
        chk("sw_setup_psel", cdc_PSEL_o, 1'b1);
        chk("sw_setup_penable", cdc_PENABLE_o, 1'b0);
        chk("sw_setup_grant", grant_o, 4'b0010);
        @(negedge clk);
        chk("sw_access_penable", cdc_PENABLE_o, 1'b1);
        chk("sw_access_pready", req_PREADY_o, 4'b0010);
        @(negedge clk);
        chk("sw_done_psel", cdc_PSEL_o, 1'b0);
        chk("sw_done_grant", grant_o, 4'b0000);
        drain("sw_drain", 20);

        // Read with five wait states and an error response.
        @(posedge clk); #1;
        set_slave(5, 32'h1234_5678, 1'b1);
        issue(2, 32'hABC, 32'hFFFF_0000, 1'b0, 1);
        push_exp(2);
        for (int c = 0; c < 30 && !req_PREADY_o[2]; c++) begin
            @(negedge clk);
            if (cdc_PENABLE_o) acc++;
        end
        chk("wait_access_cycles", 64'(acc), 64'd6);
        drain("wait_drain", 20);

        // Winner changes its command after capture.
        @(posedge clk); #1;
        set_slave(3, 32'h0F0F_0F0F, 1'b0);
        issue(0, 32'h80, 32'hCAFE_0001, 1'b1, 1);
        push_exp(0);
        repeat (2) @(posedge clk);
        #1;
        req_PADDR_i[0 +: AW]  = 32'hFFC;
        req_PWDATA_i[0 +: DW] = 32'h0;
        req_PWRITE_i[0]       = 1'b0;
        drain("iso_drain", 20);

        // Reset in ACCESS, then lowest requesting index wins.
        @(posedge clk); #1;
        set_slave(20, 32'h7777_0000, 1'b0);
        issue(2, 32'h222, 32'h2222_2222, 1'b0, 1);
        push_exp(2);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_psel", cdc_PSEL_o, 1'b0);
        chk("arst_penable", cdc_PENABLE_o, 1'b0);
        chk("arst_grant", grant_o, 4'b0000);
        sb.delete();
        set_slave(0, 32'h8888_0000, 1'b1);
        issue(3, 32'h333, 32'h3333_3333, 1'b1, 1);
        push_exp(2);
        push_exp(3);
        @(negedge clk);
        #2 rst = 1'b0;
        drain("arst_drain", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_cdc_arbiter.md
Name: apb_cdc_arbiter

Overview:
- N-to-1 APB arbiter in the source clock domain, in front of the apb_cdc source-side slave port.
- Lets several APB masters share one asynchronous bridge.
- Grants one requester at a time using round-robin, and holds the grant until the bridge returns PREADY.
- Captures the winner's command into registers, then drives one APB transfer downstream and routes the response back to the winner only.

Parameters:
- NUM_REQ, 4, number of requesting APB masters (2..16).
- APB_ADDR_WIDTH, 32, address width.
- APB_DATA_WIDTH, 32, data width.

Ports:
- clk  in  1  source-domain clock; the same clock as apb_cdc src_clk.
- rst  in  1  asynchronous active-high reset.
- req_PADDR_i  in  NUM_REQ*APB_ADDR_WIDTH  packed requester addresses; slice i belongs to requester i.
- req_PWDATA_i  in  NUM_REQ*APB_DATA_WIDTH  packed write data.
- req_PWRITE_i  in  NUM_REQ  per-requester write flag.
- req_PSEL_i  in  NUM_REQ  per-requester select; this is the request.
- req_PENABLE_i  in  NUM_REQ  per-requester enable.
- req_PRDATA_o  out  APB_DATA_WIDTH  read data, broadcast to all requesters; only meaningful for the winner.
- req_PREADY_o  out  NUM_REQ  per-requester ready.
- req_PSLVERR_o  out  NUM_REQ  per-requester error.
- cdc_PADDR_o  out  APB_ADDR_WIDTH  to the apb_cdc source port.
- cdc_PWDATA_o  out  APB_DATA_WIDTH
- cdc_PWRITE_o  out  1
- cdc_PSEL_o  out  1
- cdc_PENABLE_o  out  1
- cdc_PRDATA_i  in  APB_DATA_WIDTH
- cdc_PREADY_i  in  1
- cdc_PSLVERR_i  in  1
- grant_o  out  NUM_REQ  one-hot owner of the current transfer; all zero when IDLE.

Behaviour:
- Reset values:
  - state IDLE
  - rr_ptr = 0
  - grant_o = 0
  - cdc_PSEL_o = 0, cdc_PENABLE_o = 0
  - cdc_PADDR_o, cdc_PWDATA_o, cdc_PWRITE_o = 0
  - req_PREADY_o = 0, req_PSLVERR_o = 0, req_PRDATA_o = 0
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_PSEL_i bit is high, select the winner: the first set bit scanning upward from rr_ptr, wrapping modulo NUM_REQ.
  - Register the winner's PADDR, PWDATA and PWRITE, plus the one-hot grant, then go to SETUP.
  - With no request, stay in IDLE.
- SETUP:
  - cdc_PSEL_o = 1, cdc_PENABLE_o = 0.
  - Unconditionally go to ACCESS next cycle.
- ACCESS:
  - cdc_PSEL_o = 1, cdc_PENABLE_o = 1.
  - Hold while cdc_PREADY_i = 0; there is no limit on wait states.
  - On cdc_PREADY_i = 1, in the same cycle and combinationally:
    - req_PREADY_o[win] = 1
    - req_PSLVERR_o[win] = cdc_PSLVERR_i
    - req_PRDATA_o = cdc_PRDATA_i
  - Next state is IDLE; rr_ptr = (win+1) mod NUM_REQ; grant_o cleared.
- Non-winner req_PREADY_o bits and req_PSLVERR_o bits are always 0. Waiting requesters see wait states; APB requires them to hold their command stable.
- Downstream command registers are stable from SETUP until IDLE. Changes on the winner's inputs after capture are ignored.
- Latency: grant to cdc_PSEL_o is 1 cycle. Minimum requester transfer is 3 cycles (IDLE, SETUP, ACCESS with PREADY=1). There is always one IDLE cycle between transfers.
- Requester drops PSEL while waiting without being granted: no action, no error.
- Winner drops PSEL mid-transfer (protocol violation): the transfer completes downstream anyway, and the response is discarded.
- A requester re-asserting immediately after completion is seen in the next IDLE cycle. Round-robin places it last.
- Single active requester: it is granted back-to-back every 3+ cycles.
- Asynchronous reset mid-transfer:
  - Forces IDLE and drops cdc_PSEL_o immediately.
  - rst must be asserted together with the apb_cdc src_rst_n, because the bridge handshake is not recoverable otherwise.
- Arithmetic: rr_ptr is $clog2(NUM_REQ) bits with explicit modulo wrap. It is correct for non-power-of-2 NUM_REQ; it must never index beyond NUM_REQ-1.

Optional Feature:
- Macro: APB_CDC_ARB_PRIO0_EN.
- Defined:
  - Requester 0 is high priority. In IDLE, if req_PSEL_i[0] = 1, it wins regardless of rr_ptr.
  - rr_ptr is unchanged by a requester-0 win.
  - The other requesters rotate as normal.
- Undefined: pure round-robin over all NUM_REQ requesters; requester 0 has no special treatment.

Decomposition:
- Package apb_cdc_pkg:
  - FSM state typedef (IDLE/SETUP/ACCESS).
  - Default width localparams.
  - Function rr_pick(req, ptr) returning a one-hot grant.
- Sub-module rr_arbiter (NUM_REQ): combinational pick plus registered pointer.
  - Inputs: req, advance.
  - Outputs: grant_onehot, grant_idx.
  - Reused by later multi-port blocks.

Test Plan:
- Single write:
  - Stimulus: req1 writes PADDR=0x40, PWDATA=0xDEADBEEF, cdc_PREADY_i=1 immediately.
  - Response: cdc_PSEL_o high 1 cycle after request, cdc_PENABLE_o one cycle later; req_PREADY_o = 4'b0010 in cycle 3; rr_ptr becomes 2.
- Round-robin:
  - Stimulus: all 4 request continuously, rr_ptr=0.
  - Response: grant order 0,1,2,3,0; each grant_o one-hot.
- Wait states and read:
  - Stimulus: req2 reads, cdc_PREADY_i low for 5 cycles, then high with PRDATA=0x12345678, PSLVERR=1.
  - Response: cdc signals held stable for 5 cycles; req_PREADY_o[2]=1 and req_PSLVERR_o[2]=1 for exactly one cycle, with PRDATA=0x12345678; other bits 0.
- Capture isolation:
  - Stimulus: req0 changes PADDR during ACCESS.
  - Response: cdc_PADDR_o keeps the captured value.
- Reset mid-transfer:
  - Stimulus: assert rst during ACCESS.
  - Response: cdc_PSEL_o, cdc_PENABLE_o and grant_o = 0 asynchronously; after release, first grant goes to the lowest requesting index.
- APB_CDC_ARB_PRIO0_EN:
  - Stimulus: req0 and req3 continuously, rr_ptr=1.
  - Response: req0 wins every transfer; without the macro, grants alternate 3,0,3,0.
